mt_maint_burst: RTL

- Parametrised successor of the MT maintenance register for the MT (TM03/TU45) path of the KS10 FPGA.
- Holds the maintenance mode (MM) and maintenance opcode (MOP).
- Generates a free-running BPI reference clock with a parameterised divider.
- Drives the maintenance clock (MC) with programmable bursts of N toggles, instead of a single toggle per write.
- Sits beside the MT register file; its 16-bit mtMR image is read back through the RH data path.

---
 rtl/mt_maint_burst_pkg.sv | 40 ++++
 rtl/mt_maint_burst_if.sv | 27 ++
 rtl/mt_maint_burst_clkdiv.sv | 39 +++
 rtl/mt_maint_burst.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mt_maint_burst_pkg.sv
// Shared definitions for the MT maintenance register: field positions, extractors, enums.
package mt_maint_pkg;

    localparam int unsigned DATA_W  = 36;
    localparam int unsigned MM_BIT  = 0;
    localparam int unsigned MOP_LSB = 1;
    localparam int unsigned CNT_LSB = 8;

    // Write-pass opcodes 1..3 arm the maintenance clock by default
    localparam logic [15:0] MC_OP_MASK_DEF = 16'h000E;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_WRP1 = 4'd1,
        OP_WRP2 = 4'd2,
        OP_WRP3 = 4'd3,
        OP_RDP  = 4'd4
    } mop_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // MM bit of the RH write word
    function automatic logic fld_mm(input logic [DATA_W-1:0] d);
        return 1'(d >> MM_BIT);
    endfunction

    // Write word shifted so MOP sits at bit 0; caller truncates to MOP_W
    function automatic logic [DATA_W-1:0] fld_mop(input logic [DATA_W-1:0] d);
        return d >> MOP_LSB;
    endfunction

    // Write word shifted so the burst count sits at bit 0; caller truncates to CNT_W
    function automatic logic [DATA_W-1:0] fld_cnt(input logic [DATA_W-1:0] d);
        return d >> CNT_LSB;
    endfunction

endpackage

// File: rtl/mt_maint_burst_if.sv
// RH-side bus of the MT maintenance register.
interface mt_maint_burst_if #(
    parameter int unsigned MDF_W = 9,
    parameter int unsigned MOP_W = 4
);
    import mt_maint_pkg::*;

    localparam int unsigned MR_W = MDF_W + MOP_W + 3;

    logic [DATA_W-1:0] mtDATAI;
    logic              mtmrWRITE;
    logic              mtGO;
    logic [MDF_W-1:0]  mtMDF;
    logic [MR_W-1:0]   mtMR;
    logic              mtBUSY;

    modport master (
        output mtDATAI, mtmrWRITE, mtGO, mtMDF,
        input  mtMR, mtBUSY
    );

    modport slave (
        input  mtDATAI, mtmrWRITE, mtGO, mtMDF,
        output mtMR, mtBUSY
    );

endinterface

// File: rtl/mt_maint_burst_clkdiv.sv
// Free-running divide-and-toggle generator: output flips every DIV+1 clocks.
module mt_clkdiv #(
    parameter int unsigned DIV   = 1050,
    parameter int unsigned DIV_W = 11
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    // Count down; toggle and reload on zero
    always_comb begin
        cnt_d = cnt_q - DIV_W'(1);
        out_d = out_q;
        if (cnt_q == '0) begin
            cnt_d = RELOAD;
            out_d = ~out_q;
        end
    end

    // Divider state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= RELOAD;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign clk_out = out_q;

endmodule

// File: rtl/mt_maint_burst.sv
// MT maintenance register with BPI reference clock and burst-capable maintenance clock.
module mt_maint_burst
    import mt_maint_pkg::*;
#(
    parameter int unsigned            MDF_W      = 9,
    parameter int unsigned            MOP_W      = 4,
    parameter int unsigned            BPI_DIV    = 1050,
    parameter int unsigned            DIV_W      = 11,
    parameter logic [(2**MOP_W)-1:0]  MC_OP_MASK = (2**MOP_W)'(MC_OP_MASK_DEF),
    parameter int unsigned            GAP        = 4,
    parameter int unsigned            CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    mt_maint_burst_if.slave bus
);

    localparam int unsigned      GAP_W      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

    state_e           state_q, state_d;
    logic             mm_q, mm_d;
    logic [MOP_W-1:0] mop_q, mop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_q, mc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [2:0]       wr_q, wr_d;
    logic             trig_c;
    logic             bpiclk;

    mt_clkdiv #(
        .DIV   (BPI_DIV),
        .DIV_W (DIV_W)
    ) u_bpi (
        .clk     (clk),
        .rst     (rst),
        .clk_out (bpiclk)
    );

    // Register load, write-edge detect and MC burst sequencing
    always_comb begin
        state_d = state_q;
        mm_d    = mm_q;
        mop_d   = mop_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        wr_d    = {wr_q[1:0], bus.mtmrWRITE};
        // Trailing edge of the strobe, one trigger however wide the strobe was
        trig_c  = wr_q[2] & ~wr_q[1];

        if (bus.mtmrWRITE) begin
            mm_d  = fld_mm(bus.mtDATAI);
            mop_d = MOP_W'(fld_mop(bus.mtDATAI));
            cnt_d = CNT_W'(fld_cnt(bus.mtDATAI));
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_c && bus.mtGO && MC_OP_MASK[mop_q]) begin
                    mc_d  = ~mc_q;
                    rem_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                    gap_d = GAP_RELOAD;
                    if (rem_d != '0) begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (bus.mtmrWRITE) begin
                    state_d = ST_IDLE;
                end else if (gap_q == '0) begin
                    mc_d  = ~mc_q;
                    rem_d = rem_q - CNT_W'(1);
                    gap_d = GAP_RELOAD;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clearing MM parks the maintenance clock low and kills any burst
        if (bus.mtmrWRITE && !fld_mm(bus.mtDATAI)) begin
            mc_d    = 1'b0;
            state_d = ST_IDLE;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mm_q    <= 1'b0;
            mop_q   <= '0;
            cnt_q   <= '0;
            mc_q    <= 1'b0;
            rem_q   <= '0;
            gap_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            mm_q    <= mm_d;
            mop_q   <= mop_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.mtMR   = {bus.mtMDF, bpiclk, mc_q, mop_q, mm_q};
    assign bus.mtBUSY = (state_q == ST_BURST);

endmodule
